// File: rtl/dma_copy_engine_pkg.sv
// dma_copy_engine_pkg: register offsets, bit indices and FSM encoding for the copy DMA
package dma_copy_engine_pkg;
    localparam int DMA_XLEN  = 32;
    localparam int DMA_LEN_W = 16;
    localparam logic [2:0] REG_SRC  = 3'd0;
    localparam logic [2:0] REG_DST  = 3'd1;
    localparam logic [2:0] REG_LEN  = 3'd2;
    localparam logic [2:0] REG_CTRL = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;
    localparam logic [2:0] REG_CLR  = 3'd5;
    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return |{a, b, c};
    endfunction
endpackage

// File: rtl/dma_copy_engine_regfile.sv
// dma_copy_engine_regfile: MMIO decode, programmed registers, status flags and irq
module dma_copy_engine_regfile
    import dma_copy_engine_pkg::*;
#(
    parameter int XLEN  = DMA_XLEN,
    parameter int LEN_W = DMA_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mmio_req,
    input  logic             mmio_we,
    input  logic [2:0]       mmio_off,
    input  logic [XLEN-1:0]  mmio_wdata,
    output logic [XLEN-1:0]  mmio_rdata,
    output logic             mmio_ready,
    input  logic             busy,
    input  logic             done_set,
    input  logic             err_set,
    output logic [XLEN-1:0]  src,
    output logic [XLEN-1:0]  dst,
    output logic [LEN_W-1:0] len,
    output logic             start,
    output logic             irq
);
    logic ie, done, err;
    logic wr, clr_done, clr_err;
    assign wr         = mmio_req && mmio_we;
    assign clr_done   = wr && mmio_off == REG_CLR && mmio_wdata[STAT_DONE];
    assign clr_err    = wr && mmio_off == REG_CLR && mmio_wdata[STAT_ERR];
    assign start      = wr && mmio_off == REG_CTRL && mmio_wdata[CTRL_START] && !busy;
    assign mmio_ready = mmio_req;
    assign irq        = done && ie;
    // register storage; transfer setup is frozen while busy, a same-cycle set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src  <= '0;
            dst  <= '0;
            len  <= '0;
            ie   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (wr && !busy && mmio_off == REG_SRC) src <= mmio_wdata;
            if (wr && !busy && mmio_off == REG_DST) dst <= mmio_wdata;
            if (wr && !busy && mmio_off == REG_LEN) len <= mmio_wdata[LEN_W-1:0];
            if (wr && mmio_off == REG_CTRL) ie <= mmio_wdata[CTRL_IE];
            done <= done_set || (done && !clr_done);
            err  <= err_set || (err && !clr_err);
        end
    end
    // combinational read mux, zero when no access is in progress
    always_comb begin
        mmio_rdata = !mmio_req               ? '0 :
                     mmio_off == REG_SRC  ? src :
                     mmio_off == REG_DST  ? dst :
                     mmio_off == REG_LEN  ? XLEN'(len) :
                     mmio_off == REG_CTRL ? XLEN'({ie, 1'b0}) :
                     mmio_off == REG_STAT ? XLEN'({err, done, busy}) : '0;
    end
endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-copy DMA sequencing read/write pairs over a registered memory master
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int XLEN  = DMA_XLEN,
    parameter int LEN_W = DMA_LEN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dma_mmio_req,
    input  logic            dma_mmio_we,
    input  logic [XLEN-1:0] dma_mmio_addr,
    input  logic [XLEN-1:0] dma_mmio_wdata,
    output logic [XLEN-1:0] dma_mmio_rdata,
    output logic            dma_mmio_ready,
    output logic            dma_mem_req,
    output logic            dma_mem_we,
    output logic [XLEN-1:0] dma_mem_addr,
    output logic [XLEN-1:0] dma_mem_wdata,
    input  logic [XLEN-1:0] dma_mem_rdata,
    input  logic            dma_mem_ready,
    output logic            irq
);
    state_t state, state_d;
    logic [XLEN-1:0]  src, dst, cur_src, cur_dst, src_d, dst_d, addr_d, wdata_d;
    logic [LEN_W-1:0] len, rem, rem_d;
    logic             start, busy, done_set, err_set, req_d, we_d;
    logic             unused_addr;
    assign unused_addr = ^{dma_mmio_addr[XLEN-1:5], dma_mmio_addr[1:0]};
    assign busy = state != S_IDLE;
    dma_copy_engine_regfile #(.XLEN(XLEN), .LEN_W(LEN_W)) u_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_req   (dma_mmio_req),
        .mmio_we    (dma_mmio_we),
        .mmio_off   (dma_mmio_addr[4:2]),
        .mmio_wdata (dma_mmio_wdata),
        .mmio_rdata (dma_mmio_rdata),
        .mmio_ready (dma_mmio_ready),
        .busy       (busy),
        .done_set   (done_set),
        .err_set    (err_set),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .start      (start),
        .irq        (irq)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end
    // next state and next values of the registered memory port and working copies
    always_comb begin
        state_d  = state;
        src_d    = cur_src;
        dst_d    = cur_dst;
        rem_d    = rem;
        req_d    = dma_mem_req;
        we_d     = dma_mem_we;
        addr_d   = dma_mem_addr;
        wdata_d  = dma_mem_wdata;
        done_set = 1'b0;
        err_set  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                if (misaligned(src[1:0], dst[1:0], len[1:0])) begin
                    err_set  = 1'b1;
                    done_set = 1'b1;
                end else if (len == '0) begin
                    done_set = 1'b1;
                end else begin
                    src_d   = src;
                    dst_d   = dst;
                    rem_d   = len;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = src;
                    state_d = S_RD;
                end
            end
            S_RD: if (dma_mem_ready) begin
                wdata_d = dma_mem_rdata;
                we_d    = 1'b1;
                addr_d  = cur_dst;
                state_d = S_WR;
            end
            S_WR: if (dma_mem_ready) begin
                src_d   = cur_src + XLEN'(4);
                dst_d   = cur_dst + XLEN'(4);
                rem_d   = rem - LEN_W'(4);
                we_d    = 1'b0;
                addr_d  = cur_src + XLEN'(4);
                req_d   = rem != LEN_W'(4);
                done_set = rem == LEN_W'(4);
                state_d = rem == LEN_W'(4) ? S_IDLE : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // datapath registers; reset drops the memory request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src       <= '0;
            cur_dst       <= '0;
            rem           <= '0;
            dma_mem_req   <= 1'b0;
            dma_mem_we    <= 1'b0;
            dma_mem_addr  <= '0;
            dma_mem_wdata <= '0;
        end else begin
            cur_src       <= src_d;
            cur_dst       <= dst_d;
            rem           <= rem_d;
            dma_mem_req   <= req_d;
            dma_mem_we    <= we_d;
            dma_mem_addr  <= addr_d;
            dma_mem_wdata <= wdata_d;
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed checks of the copy DMA against a simple memory with programmable wait states
module tb_dma_copy_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dma_mmio_req = 1'b0, dma_mmio_we = 1'b0;
    logic [31:0] dma_mmio_addr = '0, dma_mmio_wdata = '0, dma_mmio_rdata;
    logic        dma_mmio_ready;
    logic        dma_mem_req, dma_mem_we, dma_mem_ready, irq;
    logic [31:0] dma_mem_addr, dma_mem_wdata, dma_mem_rdata;
    int checks = 0, errors = 0;
    int delay = 0, wcnt, acc_cnt = 0, wr_cnt = 0, req_cycles = 0;
    logic [31:0] mem [256];
    logic        pend = 1'b0, h_we;
    logic [31:0] h_addr, h_wdata;

    dma_copy_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dma_mmio_req   (dma_mmio_req),
        .dma_mmio_we    (dma_mmio_we),
        .dma_mmio_addr  (dma_mmio_addr),
        .dma_mmio_wdata (dma_mmio_wdata),
        .dma_mmio_rdata (dma_mmio_rdata),
        .dma_mmio_ready (dma_mmio_ready),
        .dma_mem_req    (dma_mem_req),
        .dma_mem_we     (dma_mem_we),
        .dma_mem_addr   (dma_mem_addr),
        .dma_mem_wdata  (dma_mem_wdata),
        .dma_mem_rdata  (dma_mem_rdata),
        .dma_mem_ready  (dma_mem_ready),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    assign dma_mem_ready = dma_mem_req && (wcnt >= delay);
    assign dma_mem_rdata = mem[dma_mem_addr[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (dma_mem_req) wcnt <= dma_mem_ready ? 0 : wcnt + 1;
    end

    always @(posedge clk) begin
        if (dma_mem_req) begin
            req_cycles++;
            if (dma_mem_ready) begin
                acc_cnt++;
                if (dma_mem_we) begin
                    mem[dma_mem_addr[9:2]] = dma_mem_wdata;
                    wr_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pend && dma_mem_req) begin
            checks++;
            assert ({dma_mem_addr, dma_mem_we, dma_mem_wdata} === {h_addr, h_we, h_wdata})
            else begin
                errors++;
                $error("FAIL mem_hold: observed %h/%b/%h expected %h/%b/%h",
                       dma_mem_addr, dma_mem_we, dma_mem_wdata, h_addr, h_we, h_wdata);
            end
        end
        pend    = dma_mem_req && !dma_mem_ready;
        h_addr  = dma_mem_addr;
        h_we    = dma_mem_we;
        h_wdata = dma_mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        @(negedge clk);
        dma_mmio_req   = 1'b1;
        dma_mmio_we    = 1'b1;
        dma_mmio_addr  = {27'h0, off, 2'b00};
        dma_mmio_wdata = d;
        @(posedge clk);
        #1;
        dma_mmio_req = 1'b0;
        dma_mmio_we  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
        @(negedge clk);
        dma_mmio_req  = 1'b1;
        dma_mmio_we   = 1'b0;
        dma_mmio_addr = {27'h0, off, 2'b00};
        #1 chk(tag, dma_mmio_rdata, exp);
        #1 dma_mmio_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            dma_mmio_req  = 1'b1;
            dma_mmio_we   = 1'b0;
            dma_mmio_addr = 32'h10;
            #1 ok = !dma_mmio_rdata[0];
            #1 dma_mmio_req = 1'b0;
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL %s: observed busy after 200 cycles expected idle", tag);
        end
    endtask

    task automatic clr_cnt();
        acc_cnt = 0;
        wr_cnt = 0;
        req_cycles = 0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        #2;
        chk("rst_mem_req", {31'h0, dma_mem_req}, 0);
        chk("rst_mem_addr", dma_mem_addr, 0);
        chk("rst_irq", {31'h0, irq}, 0);
        chk("rst_mmio_ready", {31'h0, dma_mmio_ready}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        rd_chk("rst_src", 3'd0, 0);
        rd_chk("rst_stat", 3'd4, 0);
        chk("mmio_ready_follows_req", {31'h0, dma_mmio_ready}, 0);

        // basic 16-byte copy, zero wait states
        wr(3'd0, 32'h100);
        wr(3'd1, 32'h200);
        wr(3'd2, 16);
        clr_cnt();
        wr(3'd3, 32'h1);
        rd_chk("t1_busy", 3'd4, 32'h1);
        wait_idle("t1_timeout");
        chk("t1_req_cycles", req_cycles, 8);
        chk("t1_accesses", acc_cnt, 8);
        chk("t1_writes", wr_cnt, 4);
        for (int k = 0; k < 4; k++) chk("t1_data", mem[8'h80 + k], 32'hC0DE0040 + k);
        rd_chk("t1_stat", 3'd4, 32'h2);
        rd_chk("t1_src_kept", 3'd0, 32'h100);
        rd_chk("t1_ctrl_start_reads0", 3'd3, 0);
        wr(3'd5, 32'h2);

        // same copy with three wait states per access
        delay = 3;
        wr(3'd1, 32'h280);
        clr_cnt();
        wr(3'd3, 32'h1);
        wait_idle("t2_timeout");
        chk("t2_req_cycles", req_cycles, 32);
        chk("t2_accesses", acc_cnt, 8);
        for (int k = 0; k < 4; k++) chk("t2_data", mem[8'hA0 + k], 32'hC0DE0040 + k);
        rd_chk("t2_stat", 3'd4, 32'h2);
        wr(3'd5, 32'h2);
        delay = 0;

        // zero length and misaligned starts
        clr_cnt();
        wr(3'd2, 0);
        wr(3'd3, 32'h1);
        rd_chk("t3_len0_stat", 3'd4, 32'h2);
        wr(3'd5, 32'h2);
        wr(3'd0, 32'h102);
        wr(3'd2, 16);
        wr(3'd3, 32'h1);
        rd_chk("t3_src_misaligned_stat", 3'd4, 32'h6);
        wr(3'd5, 32'h6);
        wr(3'd0, 32'h100);
        wr(3'd2, 6);
        wr(3'd3, 32'h1);
        rd_chk("t3_len_misaligned_stat", 3'd4, 32'h6);
        chk("t3_no_mem_req", req_cycles, 0);
        wr(3'd5, 32'h6);
        rd_chk("t3_stat_cleared", 3'd4, 0);

        // writes while busy are ignored
        wr(3'd2, 16);
        wr(3'd1, 32'h300);
        wr(3'd3, 32'h2);
        clr_cnt();
        wr(3'd3, 32'h3);
        wr(3'd0, 32'hDEAD);
        wr(3'd3, 32'h3);
        wait_idle("t4_timeout");
        chk("t4_writes", wr_cnt, 4);
        rd_chk("t4_src_kept", 3'd0, 32'h100);
        for (int k = 0; k < 4; k++) chk("t4_data", mem[8'hC0 + k], 32'hC0DE0040 + k);
        chk("t4_irq_high", {31'h0, irq}, 1);
        wr(3'd5, 32'h2);
        rd_chk("t4_stat_cleared", 3'd4, 0);
        chk("t4_irq_low", {31'h0, irq}, 0);

        // done set and CLR in the same cycle: set wins
        wr(3'd1, 32'h380);
        wr(3'd2, 8);
        wr(3'd3, 32'h3);
        repeat (3) @(posedge clk);
        #1 chk("t5_irq_before_done", {31'h0, irq}, 0);
        wr(3'd5, 32'h2);
        chk("t5_irq_rises", {31'h0, irq}, 1);
        rd_chk("t5_done_kept", 3'd4, 32'h2);
        for (int k = 0; k < 2; k++) chk("t5_data", mem[8'hE0 + k], 32'hC0DE0040 + k);
        wr(3'd3, 32'h0);
        chk("t5_irq_ie_cleared", {31'h0, irq}, 0);
        rd_chk("t5_done_stays", 3'd4, 32'h2);
        wr(3'd5, 32'h2);

        // reset in the middle of a write access
        delay = 3;
        wr(3'd1, 32'h200);
        wr(3'd2, 16);
        wr(3'd3, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = dma_mem_req && dma_mem_we;
        end
        chk("t6_reached_wr", {31'h0, seen}, 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_req_async_drop", {31'h0, dma_mem_req}, 0);
        dma_mmio_req  = 1'b1;
        dma_mmio_addr = 32'h0;
        #1 chk("t6_src_cleared", dma_mmio_rdata, 0);
        dma_mmio_addr = 32'h8;
        #1 chk("t6_len_cleared", dma_mmio_rdata, 0);
        dma_mmio_addr = 32'h10;
        #1 chk("t6_stat_cleared", dma_mmio_rdata, 0);
        dma_mmio_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        delay = 0;
        wr(3'd0, 32'h100);
        wr(3'd1, 32'h3C0);
        wr(3'd2, 16);
        clr_cnt();
        wr(3'd3, 32'h1);
        wait_idle("t6_timeout");
        chk("t6_writes", wr_cnt, 4);
        for (int k = 0; k < 4; k++) chk("t6_data", mem[8'hF0 + k], 32'hC0DE0040 + k);
        rd_chk("t6_stat", 3'd4, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
